// File: rtl/cascade_pi_pwm.sv
// Cascaded outer/inner PI controller feeding a triangle-carrier PWM modulator.
// Latency: adc_valid at N -> busy N+1..N+4, outer_out from N+3, done at N+4; duty applied at next carrier valley.
// Backpressure: none; adc_valid while busy is dropped, no queueing.
//
// Ports:
//   i_clk, i_rst (sync, active-high), i_enable (low clears loop state)
//   i_setpoint, i_ch0 (outer fb), i_ch1 (inner fb), i_adc_valid (sample strobe)
//   o_busy, o_done (new duty pending), o_outer_out, o_duty (active), o_pwm_out
module cascade_pi_pwm #(
   parameter int DW          = 12,
   parameter int OW          = 32,
   parameter int SHIFT       = 8,
   parameter int KP_O        = 256,
   parameter int KI_O        = 16,
   parameter int KP_I        = 512,
   parameter int KI_I        = 32,
   parameter int OUT_MIN     = 0,
   parameter int OUT_MAX     = 4095,
   parameter int CARRIER_MAX = 1000
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_enable,
   input  logic [DW-1:0]        i_setpoint,
   input  logic [DW-1:0]        i_ch0,
   input  logic [DW-1:0]        i_ch1,
   input  logic                 i_adc_valid,
   output logic                 o_busy,
   output logic                 o_done,
   output logic signed [OW-1:0] o_outer_out,
   output logic signed [OW-1:0] o_duty,
   output logic                 o_pwm_out
);

   localparam logic signed [OW-1:0] C_KP_O = OW'(KP_O);
   localparam logic signed [OW-1:0] C_KI_O = OW'(KI_O);
   localparam logic signed [OW-1:0] C_KP_I = OW'(KP_I);
   localparam logic signed [OW-1:0] C_KI_I = OW'(KI_I);
   localparam logic signed [OW-1:0] C_OMIN = OW'(OUT_MIN);
   localparam logic signed [OW-1:0] C_OMAX = OW'(OUT_MAX);
   localparam logic signed [OW-1:0] C_IMIN = '0;
   localparam logic signed [OW-1:0] C_IMAX = OW'(CARRIER_MAX);
   localparam logic signed [OW-1:0] C_ONE  = OW'(1);

   typedef enum logic [2:0] {S_IDLE, S_OUT_MUL, S_OUT_UPD, S_IN_MUL, S_IN_UPD} state_t;

   state_t                r_state;
   logic signed [OW-1:0]  r_sp, r_fb0, r_fb1;
   logic signed [OW-1:0]  r_err_o, r_prod_o, r_int_o;
   logic signed [OW-1:0]  r_err_i, r_prod_i, r_int_i;
   logic signed [OW-1:0]  r_outer_out, r_duty_pend, r_duty, r_carrier;
   logic                  r_dir_up, r_busy, r_done, r_pwm;

   logic signed [OW-1:0]  w_err_o, w_err_i, w_uraw_o, w_uraw_i, w_u_o, w_u_i;
   logic                  w_hold_o, w_hold_i;

   function automatic logic signed [OW-1:0] f_clamp(input logic signed [OW-1:0] v,
                                                    input logic signed [OW-1:0] lo,
                                                    input logic signed [OW-1:0] hi);
      if (v < lo)      return lo;
      else if (v > hi) return hi;
      else             return v;
   endfunction

   assign w_err_o  = r_sp - r_fb0;
   assign w_err_i  = r_outer_out - r_fb1;

   // Proportional term plus the integrator value from before this update.
   assign w_uraw_o = (r_prod_o + r_int_o) >>> SHIFT;
   assign w_uraw_i = (r_prod_i + r_int_i) >>> SHIFT;
   assign w_u_o    = f_clamp(w_uraw_o, C_OMIN, C_OMAX);
   assign w_u_i    = f_clamp(w_uraw_i, C_IMIN, C_IMAX);

   // Anti-windup: freeze the integrator while saturated and the error pushes further out.
   assign w_hold_o = ((w_uraw_o > C_OMAX) && !r_err_o[OW-1] && (r_err_o != '0)) ||
                     ((w_uraw_o < C_OMIN) &&  r_err_o[OW-1]);
   assign w_hold_i = ((w_uraw_i > C_IMAX) && !r_err_i[OW-1] && (r_err_i != '0)) ||
                     ((w_uraw_i < C_IMIN) &&  r_err_i[OW-1]);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_sp        <= '0;
         r_fb0       <= '0;
         r_fb1       <= '0;
         r_err_o     <= '0;
         r_prod_o    <= '0;
         r_int_o     <= '0;
         r_err_i     <= '0;
         r_prod_i    <= '0;
         r_int_i     <= '0;
         r_outer_out <= '0;
         r_duty_pend <= '0;
         r_duty      <= '0;
         r_carrier   <= '0;
         r_dir_up    <= 1'b1;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pwm       <= 1'b0;
      end else begin
         // Triangle carrier runs regardless of enable so the PWM phase is never disturbed.
         if (r_dir_up) begin
            r_carrier <= r_carrier + C_ONE;
            if (r_carrier == C_IMAX - C_ONE) r_dir_up <= 1'b0;
         end else begin
            r_carrier <= r_carrier - C_ONE;
            if (r_carrier == C_ONE) r_dir_up <= 1'b1;
         end

         if (!i_enable) begin
            r_state     <= S_IDLE;
            r_int_o     <= '0;
            r_int_i     <= '0;
            r_outer_out <= '0;
            r_duty_pend <= '0;
            r_duty      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pwm       <= 1'b0;
         end else begin
            r_done <= 1'b0;
            r_pwm  <= (r_duty > r_carrier);
            // Shadow load only at the valley so a pulse is never cut mid-period.
            if (r_carrier == '0) r_duty <= r_duty_pend;

            case (r_state)
               S_IDLE: begin
                  if (i_adc_valid) begin
                     r_sp    <= {{(OW-DW){1'b0}}, i_setpoint};
                     r_fb0   <= {{(OW-DW){1'b0}}, i_ch0};
                     r_fb1   <= {{(OW-DW){1'b0}}, i_ch1};
                     r_busy  <= 1'b1;
                     r_state <= S_OUT_MUL;
                  end
               end
               S_OUT_MUL: begin
                  r_err_o  <= w_err_o;
                  r_prod_o <= C_KP_O * w_err_o;
                  r_state  <= S_OUT_UPD;
               end
               S_OUT_UPD: begin
                  r_outer_out <= w_u_o;
                  if (!w_hold_o) r_int_o <= r_int_o + C_KI_O * r_err_o;
                  r_state <= S_IN_MUL;
               end
               S_IN_MUL: begin
                  r_err_i  <= w_err_i;
                  r_prod_i <= C_KP_I * w_err_i;
                  // Registered so the pulse is visible during the final update cycle.
                  r_done   <= 1'b1;
                  r_state  <= S_IN_UPD;
               end
               S_IN_UPD: begin
                  r_duty_pend <= w_u_i;
                  if (!w_hold_i) r_int_i <= r_int_i + C_KI_I * r_err_i;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_outer_out = r_outer_out;
   assign o_duty      = r_duty;
   assign o_pwm_out   = r_pwm;

endmodule

// File: tb/tb_cascade_pi_pwm.sv
// Testbench for cascade_pi_pwm: directed vectors, corner sequences and randomized samples.
// Latency: follows DUT timing, one compare per event.
// Backpressure: n/a.
module tb_cascade_pi_pwm;
   localparam int  CMAX = 1000;
   localparam longint SCALE = 256;

   logic clk = 1'b0;
   logic rst, enable, adc_valid;
   logic [11:0] setpoint, ch0, ch1;
   logic busy, done, pwm;
   logic signed [31:0] outer_out, duty;

   int checks = 0;
   int errors = 0;
   longint tcnt = 0;
   longint mI_o = 0, mI_i = 0;

   typedef struct {
      int     sp;
      int     c0;
      int     c1;
      longint exp_o;
      longint exp_d;
      int     exp_hi;
   } vec_t;
   vec_t vecs[8];

   cascade_pi_pwm dut (
      .i_clk(clk), .i_rst(rst), .i_enable(enable),
      .i_setpoint(setpoint), .i_ch0(ch0), .i_ch1(ch1), .i_adc_valid(adc_valid),
      .o_busy(busy), .o_done(done), .o_outer_out(outer_out), .o_duty(duty),
      .o_pwm_out(pwm)
   );

   always #5 clk = ~clk;

   // Clocks elapsed since reset release: defines the expected carrier position.
   always @(posedge clk) begin
      if (rst) tcnt <= 0;
      else     tcnt <= tcnt + 1;
   end

   function automatic longint carrier_at(input longint t);
      longint p;
      p = t % (2 * CMAX);
      return (p <= CMAX) ? p : (2 * CMAX - p);
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d expected %0d", name, act, exp);
      end
   endtask

   // Divide by 2^SHIFT, rounding toward minus infinity.
   function automatic longint floor_div(input longint v);
      if (v >= 0) return v / SCALE;
      return -((-v + SCALE - 1) / SCALE);
   endfunction

   task automatic pi_step(input longint e, input longint kp, input longint ki,
                          input longint lo, input longint hi,
                          inout longint integ, output longint u);
      longint raw;
      raw = floor_div(kp * e + integ);
      u = (raw < lo) ? lo : ((raw > hi) ? hi : raw);
      if (!((raw > hi && e > 0) || (raw < lo && e < 0))) integ = integ + ki * e;
   endtask

   task automatic model_sample(input int sp, input int c0, input int c1,
                               output longint eo, output longint ed);
      longint e;
      e = longint'(sp) - longint'(c0);
      pi_step(e, 256, 16, 0, 4095, mI_o, eo);
      e = eo - longint'(c1);
      pi_step(e, 512, 32, 0, CMAX, mI_i, ed);
   endtask

   task automatic clear_loop();
      @(negedge clk); enable = 1'b0;
      @(negedge clk); enable = 1'b1;
      mI_o = 0;
      mI_i = 0;
   endtask

   task automatic send(input int sp, input int c0, input int c1,
                       input longint exp_o, input longint exp_d, input string tag);
      int nd;
      nd = 0;
      @(negedge clk);
      setpoint = 12'(sp); ch0 = 12'(c0); ch1 = 12'(c1); adc_valid = 1'b1;
      for (int j = 1; j <= 5; j++) begin
         @(negedge clk);
         adc_valid = 1'b0;
         if (done) nd++;
         if (j == 1) chk({tag, "_busy1"}, longint'(busy), 1);
         if (j == 3) chk({tag, "_outer"}, longint'(outer_out), exp_o);
         if (j == 4) begin
            chk({tag, "_busy4"}, longint'(busy), 1);
            chk({tag, "_done4"}, longint'(done), 1);
         end
         if (j == 5) begin
            chk({tag, "_busy5"}, longint'(busy), 0);
            chk({tag, "_dpend"}, longint'(dut.r_duty_pend), exp_d);
         end
      end
      chk({tag, "_ndone"}, longint'(nd), 1);
   endtask

   task automatic wait_duty(input longint exp_d, input string tag);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 2100 && !seen; k++) begin
         if (carrier_at(tcnt) == 0) seen = 1'b1;
         else @(negedge clk);
      end
      chk({tag, "_valley"}, longint'(seen), 1);
      @(negedge clk);
      chk({tag, "_duty"}, longint'(duty), exp_d);
   endtask

   task automatic count_pwm(input int exp_hi, input string tag);
      int n;
      n = 0;
      @(negedge clk);
      repeat (2 * CMAX) begin
         @(negedge clk);
         n += int'(pwm);
      end
      chk({tag, "_pwm_high"}, longint'(n), longint'(exp_hi));
   endtask

   initial begin
      longint eo, ed;
      int nd;

      vecs[0] = '{50,   50,  0,   0,    0,    0};
      vecs[1] = '{100,  50,  0,   50,   100,  199};
      vecs[2] = '{4095, 0,   0,   4095, 1000, 1999};
      vecs[3] = '{0,    100, 0,   0,    0,    0};
      vecs[4] = '{200,  100, 30,  100,  140,  279};
      vecs[5] = '{1000, 990, 5,   10,   10,   19};
      vecs[6] = '{300,  100, 400, 200,  0,    0};
      vecs[7] = '{2000, 0,   0,   2000, 1000, 1999};

      rst = 1'b1; enable = 1'b1; adc_valid = 1'b0;
      setpoint = '0; ch0 = '0; ch1 = '0;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_busy", longint'(busy), 0);
      chk("rst_done", longint'(done), 0);
      chk("rst_outer", longint'(outer_out), 0);
      chk("rst_duty", longint'(duty), 0);
      chk("rst_pwm", longint'(pwm), 0);
      chk("rst_carrier", longint'(dut.r_carrier), 0);
      rst = 1'b0;
      repeat (7) @(negedge clk);
      chk("carrier_run", longint'(dut.r_carrier), carrier_at(tcnt));

      // Reset in the middle of a computation
      @(negedge clk); setpoint = 12'd100; ch0 = 12'd50; adc_valid = 1'b1;
      @(negedge clk); adc_valid = 1'b0;
      @(negedge clk); rst = 1'b1;
      nd = 0;
      repeat (3) begin
         @(negedge clk);
         nd += int'(done);
      end
      rst = 1'b0;
      chk("midrst_busy", longint'(busy), 0);
      chk("midrst_outer", longint'(outer_out), 0);
      chk("midrst_carrier", longint'(dut.r_carrier), 0);
      repeat (6) begin
         @(negedge clk);
         nd += int'(done);
      end
      chk("midrst_no_done", longint'(nd), 0);
      chk("midrst_outer_after", longint'(outer_out), 0);

      // Directed vectors from cleared integrators
      for (int v = 0; v < 8; v++) begin
         clear_loop();
         send(vecs[v].sp, vecs[v].c0, vecs[v].c1, vecs[v].exp_o, vecs[v].exp_d,
              $sformatf("vec%0d", v));
         wait_duty(vecs[v].exp_d, $sformatf("vec%0d", v));
         count_pwm(vecs[v].exp_hi, $sformatf("vec%0d", v));
      end

      // Saturation with anti-windup over three samples
      clear_loop();
      for (int s = 0; s < 3; s++) begin
         model_sample(4095, 0, 0, eo, ed);
         send(4095, 0, 0, 4095, 1000, $sformatf("sat%0d", s));
         chk($sformatf("sat%0d_int_o", s), longint'(dut.r_int_o), 65520);
         chk($sformatf("sat%0d_int_o_model", s), longint'(dut.r_int_o), mI_o);
      end

      // Handshake: strobes at N, N+2 (ignored) and N+5 (accepted)
      clear_loop();
      nd = 0;
      @(negedge clk); setpoint = 12'd100; ch0 = 12'd50; ch1 = 12'd0; adc_valid = 1'b1;
      for (int j = 1; j <= 12; j++) begin
         @(negedge clk);
         adc_valid = (j == 2 || j == 5);
         if (j == 4) chk("hs_done_n4", longint'(done), 1);
         if (j == 9) chk("hs_done_n9", longint'(done), 1);
         if (j <= 8) nd += int'(done);
      end
      adc_valid = 1'b0;
      chk("hs_single_done", longint'(nd), 1);

      // Enable drop after the step case
      clear_loop();
      model_sample(100, 50, 0, eo, ed);
      send(100, 50, 0, eo, ed, "en_step");
      wait_duty(100, "en_step");
      @(negedge clk); enable = 1'b0;
      @(negedge clk);
      chk("en_outer", longint'(outer_out), 0);
      chk("en_duty", longint'(duty), 0);
      chk("en_pwm", longint'(pwm), 0);
      chk("en_int_o", longint'(dut.r_int_o), 0);
      chk("en_int_i", longint'(dut.r_int_i), 0);
      chk("en_carrier", longint'(dut.r_carrier), carrier_at(tcnt));
      enable = 1'b1;
      mI_o = 0;
      mI_i = 0;

      // Randomized samples against the reference model, integrators accumulating
      for (int r = 0; r < 40; r++) begin
         int sp, c0, c1;
         sp = int'($urandom_range(0, 4095));
         c0 = sp + int'($urandom_range(0, 400)) - 200;
         if (c0 < 0) c0 = 0;
         if (c0 > 4095) c0 = 4095;
         c1 = int'($urandom_range(0, 1200));
         model_sample(sp, c0, c1, eo, ed);
         send(sp, c0, c1, eo, ed, $sformatf("rnd%0d", r));
         chk($sformatf("rnd%0d_int_o", r), longint'(dut.r_int_o), mI_o);
         chk($sformatf("rnd%0d_int_i", r), longint'(dut.r_int_i), mI_i);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      chk("rnd_carrier", longint'(dut.r_carrier), carrier_at(tcnt));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cascade_pi_pwm.md
# cascade_pi_pwm

Parametrised two-loop (outer/inner) PI controller with integrated triangle-carrier PWM modulator. It supersedes the discrete subtractor → PI → limiter → subtractor → PI → limiter → comparator chain. It adds programmable gains and limits, conditional-integration anti-windup, a sample handshake and glitch-free duty update at the carrier valley. It sits between the ADC front-end (CH0 = outer feedback, CH1 = inner feedback) and the power-stage gate driver.

## Interface
Parameters:
- DW, 12, ADC sample and setpoint width (unsigned).
- OW, 32, internal signed datapath width.
- SHIFT, 8, gain fixed-point fraction bits (gain 256 = 1.0).
- KP_O / KI_O, 256 / 16, outer proportional / integral gain.
- KP_I / KI_I, 512 / 32, inner proportional / integral gain.
- OUT_MIN / OUT_MAX, 0 / 4095, outer output clamp (inner reference).
- CARRIER_MAX, 1000, triangle carrier peak.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  loop enable; low clears the loop state.
- setpoint  in  DW  outer reference.
- ch0  in  DW  outer feedback sample.
- ch1  in  DW  inner feedback sample.
- adc_valid  in  1  one-cycle strobe; samples valid.
- busy  out  1  computation in progress.
- done  out  1  one-cycle pulse; new duty pending.
- outer_out  out  OW  clamped outer output.
- duty  out  OW  active (shadowed) duty.
- pwm_out  out  1  modulated output.

## Operation
- All inputs are zero-extended to OW signed. Error = ref − fb.
- PI step, per loop, integrator I:
  - u_raw = (KP·e + I) >>> SHIFT, using the old I.
  - u = clamp(u_raw, MIN, MAX). Inner limits are [0, CARRIER_MAX].
  - I += KI·e, except: held when u_raw > MAX and e > 0, or when u_raw < MIN and e < 0.
- FSM states IDLE → OUT_MUL → OUT_UPD → IN_MUL → IN_UPD → IDLE.
  - IDLE: on adc_valid & enable, latch setpoint/ch0/ch1 and assert busy.
  - OUT_MUL: compute outer error and product.
  - OUT_UPD: clamp; register outer_out; update outer I.
  - IN_MUL: inner error = outer_out − ch1; compute product.
  - IN_UPD: clamp into duty_pending; update inner I; pulse done.
- adc_valid while busy is ignored. No queueing.
- Carrier: up/down counter 0→CARRIER_MAX→0, period 2·CARRIER_MAX clocks, starting upward from 0 after reset.
  - duty loads from duty_pending only on the cycle carrier == 0.
  - pwm_out = (duty > carrier), registered.
- enable low:
  - Both integrators, outer_out, duty_pending and duty → 0; pwm_out → 0; FSM → IDLE.
  - Carrier keeps running.
  - An in-flight computation is abandoned.
- Overflow: no wrap protection beyond clamps. Parameters must keep KP·4095 + I within OW.

## Timing
- Reset values: busy 0, done 0, outer_out 0, duty 0, pwm_out 0, carrier 0, integrators 0, FSM IDLE.
- Reset mid-computation aborts the computation. No done pulse is produced.
- Latency:
  - adc_valid at cycle N → busy high N+1..N+4.
  - done at N+4. outer_out valid from N+3.
- Duty takes effect at the first carrier valley after done. Worst case is 2·CARRIER_MAX clocks later.
- Next accepted sample: adc_valid at N+5 earliest.
- done coincident with a valley: the new value is not taken until the following valley.
- pwm_out is registered one clock after the carrier compare.
- Duty = CARRIER_MAX gives 1999/2000 high (defaults). Duty = 0 gives constant low.

## Test plan
- Reset: hold rst 3 clocks mid-computation → all outputs 0, busy 0, no done; carrier restarts at 0.
- Balanced: setpoint 50, ch0 50, ch1 0 → outer_out 0, duty 0, pwm_out low for a full 2000-clock period.
- Step: setpoint 100, ch0 50, ch1 0 (integrators 0) → outer_out 50, outer I 800; duty 100 after the next valley; pwm_out high 199 of 2000 clocks.
- Saturation / anti-windup: setpoint 4095, ch0 0, ch1 0, three samples.
  - Sample 1: outer_out 4095, outer I 65520.
  - Samples 2–3: outer_out 4095, outer I held at 65520.
  - duty 1000; pwm_out high 1999 of 2000 clocks.
- Handshake: adc_valid pulses at N and N+2 → exactly one done (N+4). A second strobe at N+5 is accepted.
- Enable: after the step case, drop enable 1 clock → integrators, outer_out and duty read 0. pwm_out goes low next clock and the carrier continues.
